// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch side. The IF_ADEF_EN macro adds a
// per-entry address-error flag to the buffered fetch entry.
package pipe_pkg;

    localparam int PIPE_ADDR_W = 32;
    localparam int PIPE_DATA_W = 32;

    // Encoding substituted for the instruction of a misaligned fetch.
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    typedef struct packed {
        logic [PIPE_ADDR_W-1:0] pc;
        logic [PIPE_DATA_W-1:0] inst;
`ifdef IF_ADEF_EN
        logic                   adef;
`endif
    } if_entry_t;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/stage_if_buf_fetch_fifo.sv
// Generic DEPTH x WIDTH in-order FIFO with synchronous flush. The head entry is
// read straight from the storage registers, so a write is visible the next cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];

    // Explicit wrap so non power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [WIDTH-1:0] ent_q, ent_d;

            always_comb begin
                ent_d = ent_q;
                if (push && !flush && (wr_ptr_q == PTR_W'(gi))) ent_d = wr_data;
            end

            // Flush leaves contents alone; only reset clears them.
            always_ff @(posedge clk) begin
                if (rst) ent_q <= '0;
                else     ent_q <= ent_d;
            end

            assign mem[gi] = ent_q;
        end
    endgenerate

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/stage_if_buf.sv
// IF stage with a DEPTH-entry in-order buffer between pre-IF and ID.
// Define IF_ADEF_EN to tag misaligned fetches (output_adef) and replace their instruction with a NOP.
module stage_if_buf
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validin,
    output logic              allowin,
    output logic              validout,
    input  logic              allowout,
    input  logic              cancel,
    input  logic [ADDR_W-1:0] input_pc,
    input  logic [DATA_W-1:0] inst_sram_rdata,
    output logic [ADDR_W-1:0] output_pc,
    output logic [DATA_W-1:0] output_inst,
`ifdef IF_ADEF_EN
    output logic              output_adef,
`endif
    output logic [CNT_W-1:0]  occupancy
);

    // Same layout as if_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
`ifdef IF_ADEF_EN
        logic              adef;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t           wr_entry;
    entry_t           rd_entry;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign validout = (count != '0);
    assign allowin  = (count < CNT_W'(DEPTH)) | allowout;
    assign push     = validin & allowin & ~cancel;
    assign pop      = validout & allowout & ~cancel;

    always_comb begin
        wr_entry.pc   = input_pc;
        wr_entry.inst = inst_sram_rdata;
`ifdef IF_ADEF_EN
        wr_entry.adef = pc_misaligned(input_pc[1:0]);
        if (wr_entry.adef) wr_entry.inst = DATA_W'(NOP_INST);
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (cancel),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (count)
    );

    assign output_pc   = rd_entry.pc;
    assign output_inst = rd_entry.inst;
`ifdef IF_ADEF_EN
    assign output_adef = rd_entry.adef;
`endif
    assign occupancy   = count;

endmodule

// File: doc/stage_if_buf.md
Name: stage_if_buf

Overview:
- Parametrised successor to the single-register IF stage.
- Captures {pc, inst} from the synchronous inst SRAM into a DEPTH-entry in-order buffer, so decode stalls no longer back-pressure fetch immediately.
- Sits between pre-IF (PC generation / SRAM request) and ID.
- Uses the same validin/allowin/validout/allowout/cancel pipeline handshake as every other stage.

Parameters:
- DEPTH, 2, number of buffered instructions; legal range 1..16, need not be a power of 2.
- ADDR_W, 32, PC width.
- DATA_W, 32, instruction width.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- validin  in  1  pre-IF holds a valid fetch this cycle
- allowin  out  1  stage accepts a fetch this cycle
- validout  out  1  head entry valid towards ID
- allowout  in  1  ID accepts the head entry this cycle
- cancel  in  1  flush; drops all buffered entries and this cycle's incoming fetch
- input_pc  in  ADDR_W  PC of the incoming fetch
- inst_sram_rdata  in  DATA_W  SRAM data for input_pc, valid in the same cycle as validin
- output_pc  out  ADDR_W  PC of the head entry
- output_inst  out  DATA_W  instruction of the head entry
- occupancy  out  CNT_W  number of valid entries

Behaviour:
- Storage: circular buffer of DEPTH {pc, inst} entries, plus rd_ptr, wr_ptr and count.
  - Pointers increment modulo DEPTH, wrapping DEPTH-1 -> 0 explicitly; no power-of-2 masking.
- Handshake signals:
  - push = validin & allowin & ~cancel
  - pop = validout & allowout & ~cancel
  - allowin = (count < DEPTH) | allowout
  - validout = (count != 0)
- Simultaneous push and pop when full: legal. Count stays at DEPTH; the head advances and the new entry is written at the freed slot.
- Simultaneous push and pop when count == 1: the head advances to the new entry, and validout stays 1.
- Latency: an entry pushed in cycle N appears on output_pc/output_inst with validout=1 in cycle N+1 when the buffer was empty. There is no combinational bypass.
- output_pc and output_inst are driven from the entry at rd_ptr. When count == 0 they hold the last value written to that slot; ID must qualify them with validout.
- count update: count <= count + push - pop; it never exceeds DEPTH and never goes below 0.
- cancel (highest priority after rst):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, validout=0.
  - No push or pop occurs in the cancel cycle, whatever validin and allowout are.
  - Entry contents are not cleared.
  - allowin may still read 1 during cancel; the fetch it admits is dropped.
- Reset:
  - count=0, pointers 0, validout=0, occupancy=0.
  - All entries cleared to 0, so output_pc=0 and output_inst=0.
  - Reset mid-stream discards all entries, identical to cancel plus clearing the data.
- occupancy equals count, registered.
- DEPTH=1: behaves as the original single-register stage, including allowin = ~valid | allowout.

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined:
  - Each entry stores an extra bit, adef = (input_pc[1:0] != 2'b00), captured at push.
  - Extra output port output_adef (1 bit) carries the head entry's adef flag; it resets to 0.
  - For such entries output_inst is forced to 32'h0340_0000 (NOP encoding), not SRAM data.
- Not defined: no adef storage and no output_adef port; SRAM data is stored unmodified.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INST constant (32'h0340_0000)
  - ADDR_W and DATA_W defaults
  - if_entry_t typedef: {pc, inst[, adef]}
- Sub-module fetch_fifo (generic DEPTH x WIDTH synchronous FIFO with a flush input):
  - Owns the pointers, count and storage.
  - stage_if_buf wraps it, adding the handshake signals, cancel gating and the adef logic.

Test Plan:
- Reset, then push pc=0x1c000000, inst=0x02800c06 with allowout=1 -> next cycle validout=1, output_pc=0x1c000000, output_inst=0x02800c06, occupancy=1; the cycle after, occupancy=0.
- DEPTH=2, allowout=0, push PCs 0x1c000000/04/08 on consecutive cycles -> first two accepted, allowin=0 in the third cycle, occupancy=2, head pc=0x1c000000.
- Full buffer with validin=1 and allowout=1 -> pc 0x1c000008 accepted; heads seen in order 0x1c000004, then 0x1c000008; occupancy stays 2 until validin drops.
- Occupancy 2, assert cancel together with validin (pc=0x1c000100) -> next cycle validout=0, occupancy=0; a later push of 0x1c000200 is output first, confirming wrapped pointers.
- DEPTH=3, stream 7 instructions with random allowout -> outputs in exact push order; no loss or duplication across the pointer wrap 2->0.
- IF_ADEF_EN defined, push pc=0x1c000002 -> output_adef=1, output_inst=0x03400000; a following pc=0x1c000004 gives output_adef=0.
